// File: rtl/proto_pkg.sv
// Shared types and constants for the telemetry frame builder:
// frame layout, FSM states and the snapshot record.
package proto_pkg;

    localparam logic [7:0] TELEM_HEADER    = 8'hA5;
    localparam int         TELEM_FRAME_LEN = 11;

    typedef enum logic [3:0] {
        B_HDR,
        B_SEQ,
        B_FLAGS,
        B_ERR,
        B_HP_HI,
        B_HP_LO,
        B_D3,
        B_D2,
        B_D1,
        B_D0,
        B_CSUM
    } byte_idx_e;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND
    } state_e;

    // Frame bytes 1..9 exactly as they go out on the wire.
    typedef struct packed {
        logic [7:0]  seq;
        logic [7:0]  flags;
        logic [7:0]  err_cnt;
        logic [15:0] half_period;
        logic [31:0] data;
    } snap_t;

    function automatic logic [7:0] telem_checksum(input logic [7:0] header, input snap_t snap);
        logic [79:0] w_body;
        logic [7:0]  w_sum;
        w_body = {header, snap};
        w_sum  = '0;
        for (int i = 0; i < TELEM_FRAME_LEN - 1; i++) begin
            w_sum = w_sum ^ w_body[8*i +: 8];
        end
        return w_sum;
    endfunction

endpackage

// File: rtl/telemetry_sender_if.sv
// TX FIFO write port of the proto245 bridge (FPGA -> host direction).
interface telemetry_sender_if #(
    parameter int DATA_W = 8
);
    logic              txfifo_wr;
    logic [DATA_W-1:0] txfifo_data;
    logic              txfifo_full;

    modport master (output txfifo_wr, output txfifo_data, input txfifo_full);
    modport slave  (input txfifo_wr, input txfifo_data, output txfifo_full);
endinterface

// File: rtl/telem_err_counter.sv
// Counts rising edges of the receiver error level; the count and sticky flag
// are cleared on snapshot, with an edge in that same cycle winning over the clear.
module telem_err_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_read_error,
    input  logic       i_clear,
    output logic [7:0] o_err_cnt,
    output logic       o_err_sticky
);

    logic       r_read_error_d;
    logic [7:0] r_err_cnt;
    logic       r_err_sticky;
    logic       w_edge;

    assign w_edge = i_read_error && !r_read_error_d;

    // NOTE: non-blocking everywhere so the edge detect compares against last cycle's level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_error_d <= 1'b0;
            r_err_cnt      <= '0;
            r_err_sticky   <= 1'b0;
        end else begin
            r_read_error_d <= i_read_error;
            if (i_clear) begin
                r_err_cnt    <= w_edge ? 8'd1 : 8'd0;
                r_err_sticky <= w_edge;
            end else if (w_edge) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign o_err_cnt    = r_err_cnt;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: rtl/telemetry_sender.sv
// Builds 11-byte status frames from receiver state and streams them into the
// TX FIFO, on request or on a periodic timer.
module telemetry_sender
    import proto_pkg::*;
#(
    parameter int         DATA_W        = 8,
    parameter int         PERIOD_CYCLES = 0,
    parameter logic [7:0] HEADER        = TELEM_HEADER
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      report_req,
    input  logic                      read_error,
    input  logic                      mod_enable,
    input  logic [15:0]               mod_half_period,
    input  logic [31:0]               latest_data,
    telemetry_sender_if.master        tx,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    localparam bit          TIMER_ON   = (PERIOD_CYCLES > 0);
    localparam logic [31:0] TIMER_LAST = TIMER_ON ? 32'(PERIOD_CYCLES - 1) : 32'd0;

    state_e            r_state;
    state_e            w_state_next;
    byte_idx_e         r_idx;
    snap_t             r_snap;
    snap_t             w_snap_next;
    logic [7:0]        r_csum;
    logic [7:0]        r_seq;
    logic [7:0]        r_drop_cnt;
    logic              r_pending;
    logic [31:0]       r_timer;
    logic              w_timer_exp;
    logic              w_trig;
    logic              w_wr;
    logic              w_last;
    logic [7:0]        w_err_cnt;
    logic              w_err_sticky;
    logic [DATA_W-1:0] w_byte;

    telem_err_counter u_err (
        .clk          (clk),
        .rst          (rst),
        .i_read_error (read_error),
        .i_clear      (r_state == SNAP),
        .o_err_cnt    (w_err_cnt),
        .o_err_sticky (w_err_sticky)
    );

    assign w_timer_exp = TIMER_ON && (r_timer == TIMER_LAST);
    assign w_trig      = report_req || w_timer_exp;
    assign w_wr        = (r_state == SEND) && !tx.txfifo_full;
    assign w_last      = (r_idx == B_CSUM);

    assign w_snap_next = '{
        seq:         r_seq,
        flags:       {6'b0, mod_enable, w_err_sticky},
        err_cnt:     w_err_cnt,
        half_period: mod_half_period,
        data:        latest_data
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (TIMER_ON) begin
            r_timer <= w_timer_exp ? 32'd0 : r_timer + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= B_HDR;
            r_snap     <= '0;
            r_csum     <= '0;
            r_seq      <= '0;
            r_drop_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Leaving IDLE always consumes the pending request; once busy, one more
            // trigger is remembered and any further ones are counted as dropped.
            if (r_state == IDLE) begin
                r_pending <= 1'b0;
            end else if (w_trig) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end

            if (r_state == SNAP) begin
                r_snap <= w_snap_next;
                r_csum <= telem_checksum(HEADER, w_snap_next);
                r_idx  <= B_HDR;
            end

            if (w_wr) begin
                if (w_last) begin
                    r_seq <= r_seq + 8'd1;
                end else begin
                    r_idx <= byte_idx_e'(r_idx + 4'd1);
                end
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_trig || r_pending) w_state_next = SNAP;
            SNAP:    w_state_next = SEND;
            SEND:    if (w_wr && w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = '0;
        if (r_state == SEND) begin
            unique case (r_idx)
                B_HDR:   w_byte = HEADER;
                B_SEQ:   w_byte = r_snap.seq;
                B_FLAGS: w_byte = r_snap.flags;
                B_ERR:   w_byte = r_snap.err_cnt;
                B_HP_HI: w_byte = r_snap.half_period[15:8];
                B_HP_LO: w_byte = r_snap.half_period[7:0];
                B_D3:    w_byte = r_snap.data[31:24];
                B_D2:    w_byte = r_snap.data[23:16];
                B_D1:    w_byte = r_snap.data[15:8];
                B_D0:    w_byte = r_snap.data[7:0];
                B_CSUM:  w_byte = r_csum;
                default: w_byte = '0;
            endcase
        end
    end

    assign tx.txfifo_wr   = w_wr;
    assign tx.txfifo_data = w_byte;
    assign busy           = (r_state != IDLE);
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_telemetry_sender.sv
// Scoreboard bench: stimulus pushes expected frame bytes, monitors pop and compare
// on every FIFO write. A second instance with PERIOD_CYCLES=100 exercises the timer.
module tb_telemetry_sender;
    import proto_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_rst;
    logic        report_req;
    logic        read_error;
    logic        mod_enable;
    logic [15:0] mod_half_period;
    logic [31:0] latest_data;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        t_busy;
    logic [7:0]  t_drop_cnt;
    logic        t_req  = 1'b0;
    logic        t_err  = 1'b0;
    logic        t_en   = 1'b0;
    logic [15:0] t_hp   = 16'h0064;
    logic [31:0] t_data = 32'h0;

    always #5 clk = ~clk;

    telemetry_sender_if tx_if ();
    telemetry_sender_if t_if ();

    telemetry_sender #(.PERIOD_CYCLES(0)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .report_req      (report_req),
        .read_error      (read_error),
        .mod_enable      (mod_enable),
        .mod_half_period (mod_half_period),
        .latest_data     (latest_data),
        .tx              (tx_if),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    telemetry_sender #(.PERIOD_CYCLES(100)) u_tmr (
        .clk             (clk),
        .rst             (t_rst),
        .report_req      (t_req),
        .read_error      (t_err),
        .mod_enable      (t_en),
        .mod_half_period (t_hp),
        .latest_data     (t_data),
        .tx              (t_if),
        .busy            (t_busy),
        .drop_cnt        (t_drop_cnt)
    );

    typedef struct {
        logic [7:0] b;
        int         idx;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   start_q[$];
    int   last_end_cyc = 0;
    int   req_cyc = 0;
    int   idle_cyc = 0;
    int   m_seq = 0;
    int   m_edges = 0;
    int   m_drop = 0;
    int   t_pos = 0;
    int   t_frames = 0;
    int   t_start[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame as the host sees it, built straight from the byte-order table.
    function automatic logic [7:0] frame_byte(input int idx, input int seq, input logic en,
                                              input int edges, input logic [15:0] hp,
                                              input logic [31:0] d);
        logic [79:0] body;
        logic [7:0]  cs;
        logic        sticky;
        int          e;
        e      = (edges > 255) ? 255 : edges;
        sticky = (edges > 0);
        body   = {TELEM_HEADER, 8'(seq), 6'b0, en, sticky, 8'(e), hp, d};
        if (idx < 10) return body[79-8*idx -: 8];
        cs = 8'h00;
        for (int i = 0; i < 10; i++) cs = cs ^ body[79-8*i -: 8];
        return cs;
    endfunction

    function automatic void push_frame();
        for (int i = 0; i < TELEM_FRAME_LEN; i++) begin
            exp_q.push_back('{b: frame_byte(i, m_seq, mod_enable, m_edges, mod_half_period, latest_data), idx: i});
        end
        m_seq   = (m_seq + 1) % 256;
        m_edges = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request();
        report_req = 1'b1;
        req_cyc    = cyc;
        push_frame();
        step();
        report_req = 1'b0;
    endtask

    task automatic pulse_err(input int n);
        repeat (n) begin
            read_error = 1'b1;
            step();
            read_error = 1'b0;
            step();
            m_edges++;
        end
    endtask

    task automatic wait_idle(input bit rnd_bp);
        int k;
        for (k = 0; k < 400; k++) begin
            if (!busy && exp_q.size() == 0) break;
            tx_if.txfifo_full = rnd_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
        end
        tx_if.txfifo_full = 1'b0;
        idle_cyc = cyc;
        if (k == 400) begin
            total++;
            bad++;
            $display("FAIL wait_idle: frame still open after 400 cycles, %0d bytes outstanding", exp_q.size());
        end
    endtask

    // Main scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_if.txfifo_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_wr: got byte %02h, expected no write", tx_if.txfifo_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", e.idx), 32'(tx_if.txfifo_data), 32'(e.b));
                    if (e.idx == 0) start_q.push_back(cyc);
                    if (e.idx == TELEM_FRAME_LEN - 1) last_end_cyc = cyc;
                end
            end
        end
    end

    // Timer-instance monitor: constant inputs, so frame k carries seq k and no errors.
    initial begin
        t_if.txfifo_full = 1'b0;
        forever begin
            @(negedge clk);
            if (t_if.txfifo_wr === 1'b1) begin
                if (t_frames < 10) begin
                    check($sformatf("tmr_f%0d_b%0d", t_frames, t_pos), 32'(t_if.txfifo_data),
                          32'(frame_byte(t_pos, t_frames, 1'b0, 0, 16'h0064, 32'h0)));
                end
                if (t_pos == 0) t_start.push_back(cyc);
                t_pos++;
                if (t_pos == TELEM_FRAME_LEN) begin
                    t_pos = 0;
                    t_frames++;
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        int         k;

        rst               = 1'b1;
        t_rst             = 1'b1;
        report_req        = 1'b0;
        read_error        = 1'b0;
        mod_enable        = 1'b0;
        mod_half_period   = '0;
        latest_data       = '0;
        tx_if.txfifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr",    32'(tx_if.txfifo_wr),   32'd0);
        check("rst_data",  32'(tx_if.txfifo_data), 32'd0);
        check("rst_busy",  32'(busy),              32'd0);
        check("rst_drop",  32'(drop_cnt),          32'd0);
        #2;
        rst   = 1'b0;
        t_rst = 1'b0;
        step();

        // Basic frame: A5 00 02 00 12 34 DE AD BE EF csum.
        mod_enable      = 1'b1;
        mod_half_period = 16'h1234;
        latest_data     = 32'hDEADBEEF;
        request();
        wait_idle(1'b0);
        check("first_wr_latency", 32'(start_q[$] - req_cyc), 32'd2);
        check("busy_fall",        32'(idle_cyc - last_end_cyc), 32'd1);

        // Back-pressure for 5 cycles starting at byte 3.
        request();
        repeat (4) step();
        held = exp_q[0].b;
        tx_if.txfifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_no_wr",   32'(tx_if.txfifo_wr),   32'd0);
            check("bp_hold_b3", 32'(tx_if.txfifo_data), 32'(held));
            step();
        end
        tx_if.txfifo_full = 1'b0;
        wait_idle(1'b0);
        check("bp_send_cycles", 32'(last_end_cyc - start_q[$] + 1), 32'd16);

        // Error tracking: 3 edges, then a clean frame, then saturation.
        pulse_err(3);
        request();
        wait_idle(1'b0);
        request();
        wait_idle(1'b0);
        pulse_err(300);
        request();
        wait_idle(1'b0);

        // Random frames with random back-pressure.
        for (int n = 0; n < 12; n++) begin
            mod_enable      = 1'($urandom_range(0, 1));
            mod_half_period = 16'($urandom);
            latest_data     = $urandom;
            pulse_err(int'($urandom_range(0, 4)));
            request();
            wait_idle(1'b1);
        end

        // Asynchronous reset while byte 5 is on the bus.
        request();
        repeat (6) step();
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_seq   = 0;
        m_edges = 0;
        m_drop  = 0;
        #1;
        check("midrst_wr",   32'(tx_if.txfifo_wr), 32'd0);
        check("midrst_busy", 32'(busy),            32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("midrst_drop", 32'(drop_cnt), 32'd0);
        mod_enable      = 1'b0;
        mod_half_period = 16'hBEEF;
        latest_data     = 32'h01234567;
        request();
        wait_idle(1'b0);

        // Three requests during one frame: one pending, one dropped.
        request();
        repeat (3) step();
        report_req = 1'b1;
        push_frame();
        step();
        report_req = 1'b0;
        repeat (2) step();
        report_req = 1'b1;
        m_drop++;
        step();
        report_req = 1'b0;
        wait_idle(1'b0);
        check("ovf_drop_cnt",     32'(drop_cnt), 32'(m_drop));
        check("ovf_back_to_back", 32'(start_q[$] - start_q[$-1]), 32'd13);

        // Let the timer instance produce at least 10 frames.
        for (k = 0; k < 3000; k++) begin
            if (t_frames >= 10) break;
            step();
        end
        if (k == 3000) begin
            total++;
            bad++;
            $display("FAIL tmr_frames: got %0d frames, expected at least 10", t_frames);
        end
        for (int i = 1; i < 10 && i < t_start.size(); i++) begin
            check($sformatf("tmr_spacing%0d", i), 32'(t_start[i] - t_start[i-1]), 32'd100);
        end
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
